// File: rtl/instruction_loader.sv
// instruction_loader
// Receives a program as a byte stream over a valid/ready handshake and
// assembles the bytes into instruction words, most significant byte first.
// Each finished word is written to instruction memory at consecutive
// addresses starting from 0. Loading ends when the HALT opcode has been
// written. If memory fills before a HALT arrives, the error flag is raised.

module instruction_loader #(
    parameter int DATA_WIDTH = 32,
    parameter int DATA_DEPTH = 128,
    parameter int ADDR_WIDTH = 7
) (
    input  logic                  i_clk,
    input  logic                  i_reset,
    input  logic                  i_start,
    input  logic [7:0]            i_byte,
    input  logic                  i_byte_valid,
    output logic                  o_byte_ready,
    output logic                  o_wr_en,
    output logic [ADDR_WIDTH-1:0] o_wr_addr,
    output logic [DATA_WIDTH-1:0] o_wr_data,
    output logic [ADDR_WIDTH:0]   o_word_count,
    output logic                  o_busy,
    output logic                  o_done,
    output logic                  o_overflow
);

    localparam int BYTES = DATA_WIDTH / 8;
    localparam int CNT_W = (BYTES > 1) ? $clog2(BYTES) : 1;

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_RECEIVE = 3'd1;
    localparam logic [2:0] S_WRITE   = 3'd2;
    localparam logic [2:0] S_DONE    = 3'd3;
    localparam logic [2:0] S_ERROR   = 3'd4;

    logic [2:0]            state;
    logic [DATA_WIDTH-1:0] word;
    logic [DATA_WIDTH-1:0] wr_data;
    logic [CNT_W-1:0]      byte_cnt;
    logic [ADDR_WIDTH-1:0] addr;
    logic [ADDR_WIDTH:0]   word_count;

    logic                  xfer;
    logic                  last_byte;
    logic                  is_halt;
    logic                  addr_full;
    logic [DATA_WIDTH-1:0] next_word;

    // Decode the handshake and the word-completion conditions.
    // A finished word is copied into wr_data, so the value on o_wr_data
    // stays fixed while the next word is being shifted in.
    always_comb begin
        xfer      = i_byte_valid && (state == S_RECEIVE);
        last_byte = (byte_cnt == CNT_W'(BYTES - 1));
        next_word = (word << 8) | DATA_WIDTH'(i_byte);
        is_halt   = (wr_data[DATA_WIDTH-1 -: 6] == 6'b111111);
        addr_full = (addr == ADDR_WIDTH'(DATA_DEPTH - 1));
    end

    // The load state machine and its datapath registers.
    // i_start is honoured only while no session is running.
    // A new session clears the address, both counters and the flags.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state      <= S_IDLE;
            word       <= '0;
            wr_data    <= '0;
            byte_cnt   <= '0;
            addr       <= '0;
            word_count <= '0;
        end else begin
            case (state)
                S_IDLE, S_DONE, S_ERROR: begin
                    if (i_start) begin
                        state      <= S_RECEIVE;
                        byte_cnt   <= '0;
                        addr       <= '0;
                        word_count <= '0;
                    end
                end
                S_RECEIVE: begin
                    if (xfer) begin
                        word <= next_word;
                        if (last_byte) begin
                            wr_data  <= next_word;
                            byte_cnt <= '0;
                            state    <= S_WRITE;
                        end else begin
                            byte_cnt <= byte_cnt + CNT_W'(1);
                        end
                    end
                end
                S_WRITE: begin
                    word_count <= word_count + (ADDR_WIDTH + 1)'(1);
                    if (is_halt) begin
                        state <= S_DONE;
                    end else if (addr_full) begin
                        state <= S_ERROR;
                    end else begin
                        addr  <= addr + ADDR_WIDTH'(1);
                        state <= S_RECEIVE;
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    // Every output is taken directly from a register or decoded from the state.
    always_comb begin
        o_byte_ready = (state == S_RECEIVE);
        o_wr_en      = (state == S_WRITE);
        o_wr_addr    = addr;
        o_wr_data    = wr_data;
        o_word_count = word_count;
        o_busy       = (state == S_RECEIVE) || (state == S_WRITE);
        o_done       = (state == S_DONE);
        o_overflow   = (state == S_ERROR);
    end

endmodule
